// File: rtl/sr_ff_pkg.sv
// Shared encodings for the clocked SR flip-flop bank: conflict policies,
// {s,r} pair constants and the filter stability-counter width helper.
package sr_ff_pkg;

    // Behaviour when a channel applies S=R=1
    typedef enum logic [1:0] {
        SR_HOLD    = 2'd0,
        SR_SET_DOM = 2'd1,
        SR_RST_DOM = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_conflict_e;

    // {s,r} pair encodings
    localparam logic [1:0] PAIR_HOLD = 2'b00;
    localparam logic [1:0] PAIR_RST  = 2'b01;
    localparam logic [1:0] PAIR_SET  = 2'b10;
    localparam logic [1:0] PAIR_BOTH = 2'b11;

    // Stability counter holds 0..FILT-1; never narrower than one bit
    function automatic int unsigned stab_width(input int unsigned filt);
        return (filt > 1) ? $clog2(filt) : 1;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: input stability filter, state bit with complementary
// output, and a registered flag for applied S=R=1 pairs.
module sr_ff_cell
    import sr_ff_pkg::*;
#(
    parameter int unsigned  FILT   = 2,
    parameter sr_conflict_e POLICY = SR_SET_DOM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar,
    output logic conflict,
    output logic applied_11
);

    localparam int unsigned     SW       = stab_width(FILT);
    localparam logic [SW-1:0]   STAB_MAX = SW'(FILT - 1);

    logic [1:0]    raw;
    logic [1:0]    cand_q, cand_d;
    logic [SW-1:0] stab_q, stab_d;
    logic          q_q, q_d;
    logic          conflict_q, conflict_d;
    logic          applied;

    assign raw = {s, r};

    // Track the candidate pair and how many consecutive edges it has been seen
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (raw != cand_q) begin
            cand_d = raw;
            stab_d = '0;
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + SW'(1);
        end
    end

    // The pair takes effect on the edge that completes FILT identical samples
    // and on every later edge it stays present; FILT=1 makes this always true.
    assign applied    = (stab_d == STAB_MAX);
    assign applied_11 = applied && (raw == PAIR_BOTH);

    // Next state of the channel bit from the applied pair and conflict policy
    always_comb begin
        q_d        = q_q;
        conflict_d = applied_11;
        if (applied) begin
            case (raw)
                PAIR_RST: q_d = 1'b0;
                PAIR_SET: q_d = 1'b1;
                PAIR_BOTH: begin
                    case (POLICY)
                        SR_HOLD:    q_d = q_q;
                        SR_SET_DOM: q_d = 1'b1;
                        SR_RST_DOM: q_d = 1'b0;
                        SR_TOGGLE:  q_d = ~q_q;
                        default:    q_d = q_q;
                    endcase
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Channel state; reset leaves the filter saturated on the idle pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q     <= PAIR_HOLD;
            stab_q     <= STAB_MAX;
            q_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign qbar     = ~q_q;
    assign conflict = conflict_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH filtered SR flip-flops with a shared saturating counter of
// edges on which any channel applied S=R=1.
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned FILT     = 2,
    parameter int unsigned CONFLICT = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  s,
    input  logic [WIDTH-1:0]  r,
    input  logic              clr_cnt,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qbar,
    output logic [WIDTH-1:0]  conflict,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [1:0]   CONFLICT_SEL = CONFLICT[1:0];
    localparam sr_conflict_e POLICY       = sr_conflict_e'(CONFLICT_SEL);

    logic [WIDTH-1:0] applied_11;
    logic             any_11;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sr_ff_cell #(
            .FILT   (FILT),
            .POLICY (POLICY)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .s          (s[i]),
            .r          (r[i]),
            .q          (q[i]),
            .qbar       (qbar[i]),
            .conflict   (conflict[i]),
            .applied_11 (applied_11[i])
        );
    end

    // Several channels in conflict on one edge still count once
    assign any_11 = |applied_11;

    // Saturating conflict counter; clear beats a same-edge increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (any_11 && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four FILT=1 banks (one per conflict policy, 3-bit
// counter) and one FILT=3 toggle bank share stimulus; a behavioural model
// pushes expected outputs per edge and they are popped after the edge.
module tb_sr_ff_bank;

    localparam int NI = 5;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;
    logic clr_cnt = 1'b0;

    logic [NI-1:0][W-1:0] q_o, qb_o, cf_o;
    logic [3:0][2:0]      cnt3;
    logic [7:0]           cnt4;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_pol
        sr_ff_bank #(.WIDTH(W), .FILT(1), .CONFLICT(g), .CNT_W(3)) u_dut (
            .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_cnt(clr_cnt),
            .q(q_o[g]), .qbar(qb_o[g]), .conflict(cf_o[g]), .conflict_cnt(cnt3[g])
        );
    end

    sr_ff_bank #(.WIDTH(W), .FILT(3), .CONFLICT(3), .CNT_W(8)) u_dut_f3 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_cnt(clr_cnt),
        .q(q_o[4]), .qbar(qb_o[4]), .conflict(cf_o[4]), .conflict_cnt(cnt4)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] cf;
        int unsigned  cnt;
    } exp_t;

    exp_t sb_q[$];

    logic [1:0]   m_prev [NI][W];
    int unsigned  m_run  [NI][W];
    logic [W-1:0] m_q    [NI];
    int unsigned  m_cnt  [NI];

    function automatic int unsigned filt_of(input int k);
        return (k < 4) ? 1 : 3;
    endfunction

    function automatic int unsigned pol_of(input int k);
        return (k < 4) ? k : 3;
    endfunction

    function automatic int unsigned cmax_of(input int k);
        return (k < 4) ? 7 : 255;
    endfunction

    function automatic logic [31:0] cnt_obs(input int k);
        return (k < 4) ? 32'(cnt3[k]) : 32'(cnt4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < W; i++) begin
                m_prev[k][i] = 2'b00;
                m_run[k][i]  = filt_of(k);
            end
            m_q[k]   = '0;
            m_cnt[k] = 0;
        end
    endtask

    // Run-length model: a pair counts once it has been sampled FILT edges in a row
    task automatic model_step();
        exp_t e;
        logic [1:0] raw;
        logic any11, app;
        for (int k = 0; k < NI; k++) begin
            any11 = 1'b0;
            e.cf  = '0;
            for (int i = 0; i < W; i++) begin
                raw = {s[i], r[i]};
                if (raw == m_prev[k][i]) begin
                    if (m_run[k][i] < filt_of(k)) m_run[k][i]++;
                end else begin
                    m_prev[k][i] = raw;
                    m_run[k][i]  = 1;
                end
                app = (m_run[k][i] >= filt_of(k));
                if (app) begin
                    if (raw == 2'b01) m_q[k][i] = 1'b0;
                    else if (raw == 2'b10) m_q[k][i] = 1'b1;
                    else if (raw == 2'b11) begin
                        e.cf[i] = 1'b1;
                        any11   = 1'b1;
                        if (pol_of(k) == 1) m_q[k][i] = 1'b1;
                        else if (pol_of(k) == 2) m_q[k][i] = 1'b0;
                        else if (pol_of(k) == 3) m_q[k][i] = ~m_q[k][i];
                    end
                end
            end
            if (clr_cnt) m_cnt[k] = 0;
            else if (any11 && m_cnt[k] < cmax_of(k)) m_cnt[k]++;
            e.q   = m_q[k];
            e.cnt = m_cnt[k];
            sb_q.push_back(e);
        end
    endtask

    task automatic drive(input logic [W-1:0] sv, input logic [W-1:0] rv, input logic clr);
        exp_t e;
        logic [W-1:0] nq;
        s = sv;
        r = rv;
        clr_cnt = clr;
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            e  = sb_q.pop_front();
            nq = ~e.q;
            check($sformatf("q%0d", k),    32'(q_o[k]),  32'(e.q));
            check($sformatf("qbar%0d", k), 32'(qb_o[k]), 32'(nq));
            check($sformatf("conf%0d", k), 32'(cf_o[k]), 32'(e.cf));
            check($sformatf("cnt%0d", k),  cnt_obs(k),   e.cnt);
        end
    endtask

    int pol_seq [4][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{0, 0, 0}, '{0, 1, 0}};

    initial begin
        logic [W-1:0] rs, rr;

        // Reset
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_q%0d", k),    32'(q_o[k]),  32'h0);
            check($sformatf("rst_qbar%0d", k), 32'(qb_o[k]), 32'hf);
            check($sformatf("rst_conf%0d", k), 32'(cf_o[k]), 32'h0);
            check($sformatf("rst_cnt%0d", k),  cnt_obs(k),   32'h0);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // No filtering: single-edge set then reset
        drive(4'b0001, 4'b0000, 1'b0);
        check("nofilt_set", 32'(q_o[0]), 32'h1);
        drive(4'b0000, 4'b0001, 1'b0);
        check("nofilt_rst", 32'(q_o[0]), 32'h0);

        // Glitch rejection on the FILT=3 bank
        drive(4'b0001, 4'b0000, 1'b0);
        drive(4'b0001, 4'b0000, 1'b0);
        check("glitch_2edges", 32'(q_o[4][0]), 32'h0);
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        check("glitch_dropped", 32'(q_o[4][0]), 32'h0);
        drive(4'b0001, 4'b0000, 1'b0);
        drive(4'b0001, 4'b0000, 1'b0);
        check("filt_edge2", 32'(q_o[4][0]), 32'h0);
        drive(4'b0001, 4'b0000, 1'b0);
        check("filt_edge3", 32'(q_o[4][0]), 32'h1);

        // Conflict policies from q=1
        drive(4'b0001, 4'b0000, 1'b0);
        for (int t = 0; t < 3; t++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            for (int p = 0; p < 4; p++) begin
                check($sformatf("pol%0d_t%0d_q", p, t), 32'(q_o[p][0]), 32'(pol_seq[p][t]));
                check($sformatf("pol%0d_t%0d_cf", p, t), 32'(cf_o[p][0]), 32'h1);
            end
        end

        // Counter saturation and clear priority
        drive(4'b0000, 4'b0000, 1'b1);
        check("cnt_clr", 32'(cnt3[0]), 32'h0);
        for (int t = 0; t < 10; t++) drive(4'b0011, 4'b0011, 1'b0);
        check("cnt_sat", 32'(cnt3[0]), 32'h7);
        drive(4'b0011, 4'b0011, 1'b1);
        check("cnt_clr_wins", 32'(cnt3[0]), 32'h0);
        drive(4'b0011, 4'b0011, 1'b0);
        check("cnt_after_clr", 32'(cnt3[0]), 32'h1);

        // Async reset with a partial filter count pending
        for (int t = 0; t < 3; t++) drive(4'b1111, 4'b0000, 1'b0);
        check("pre_rst_q", 32'(q_o[4]), 32'hf);
        drive(4'b0000, 4'b0001, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_q",    32'(q_o[4]),  32'h0);
        check("async_qbar", 32'(qb_o[4]), 32'hf);
        check("async_cnt",  cnt_obs(4),   32'h0);
        check("async_q0",   32'(q_o[0]),  32'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        drive(4'b1111, 4'b0000, 1'b0);
        drive(4'b1111, 4'b0000, 1'b0);
        check("post_rst_edge2", 32'(q_o[4]), 32'h0);
        drive(4'b1111, 4'b0000, 1'b0);
        check("post_rst_edge3", 32'(q_o[4]), 32'hf);

        // Random run; inputs mostly held so the FILT=3 bank also applies pairs
        rs = '0;
        rr = '0;
        for (int t = 0; t < 10000; t++) begin
            if ($urandom_range(3) == 0) begin
                rs = W'($urandom);
                rr = W'($urandom);
            end
            drive(rs, rr, ($urandom_range(15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
